// File: rtl/hba_mailbox_pkg.sv
// Register map and bit positions shared by the mailbox top and its bench.
package hba_mailbox_pkg;

   typedef enum logic [7:0] {
      REG_CTRL   = 8'h00,
      REG_STATUS = 8'h01,
      REG_COUNT  = 8'h02,
      REG_DATA   = 8'h03,
      REG_THRESH = 8'h04
   } reg_addr_e;

   // CTRL bit positions
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_FLUSH  = 2;

   // STATUS bit positions
   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVF   = 2;
   localparam int STAT_UDF   = 3;

endpackage

// File: rtl/hba_mailbox_fifo.sv
// Synchronous byte FIFO with flush; head entry is presented combinationally.
module hba_mailbox_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic [WIDTH-1:0]      din_i,
   output logic [WIDTH-1:0]      dout_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next-state for pointers and occupancy; flush wins over everything.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write port.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; occupancy alone defines which entries are valid.
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/hba_mailbox.sv
// HBA responder: address decode, one-cycle ack, mailbox registers, interrupt.
module hba_mailbox
   import hba_mailbox_pkg::*;
#(
   parameter int DBUS_WIDTH        = 8,
   parameter int PERIPH_ADDR_WIDTH = 4,
   parameter int REG_ADDR_WIDTH    = 8,
   parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
   parameter int PERIPH_ADDR       = 0,
   parameter int DEPTH_LOG2        = 4
) (
   input  logic                  hba_clk,
   input  logic                  hba_reset,
   input  logic [ADDR_WIDTH-1:0] hba_abus,
   input  logic                  hba_select,
   input  logic                  hba_rnw,
   input  logic [DBUS_WIDTH-1:0] hba_dbus,
   output logic                  hba_xferack_slave,
   output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
   output logic                  slave_interrupt
);

   logic                      ack_q;
   logic [DBUS_WIDTH-1:0]     rdata_q, rdata_d;
   logic                      enable_q, enable_d;
   logic                      irq_en_q, irq_en_d;
   logic [DBUS_WIDTH-1:0]     thresh_q, thresh_d;
   logic                      ovf_q, ovf_d;
   logic                      udf_q, udf_d;
   logic                      irq_q, irq_d;

   logic                      hit;
   logic [REG_ADDR_WIDTH-1:0] reg_addr;
   logic                      push, pop, flush;
   logic [DBUS_WIDTH-1:0]     fifo_dout;
   logic [DEPTH_LOG2:0]       fifo_count;
   logic                      fifo_empty, fifo_full;
   logic [DBUS_WIDTH-1:0]     count_ext, ctrl_rd, status_rd;

   // A transfer is never accepted during its own ack cycle.
   assign hit = hba_select
              & (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR))
              & ~ack_q;
   assign reg_addr  = hba_abus[REG_ADDR_WIDTH-1:0];
   assign count_ext = DBUS_WIDTH'(fifo_count);

   hba_mailbox_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (DBUS_WIDTH)
   ) u_fifo (
      .clk_i   (hba_clk),
      .rst_n_i (hba_reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   (hba_dbus),
      .dout_o  (fifo_dout),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Read-back images of CTRL and STATUS; flush is never stored so reads 0.
   always_comb begin
      ctrl_rd                = '0;
      ctrl_rd[CTRL_ENABLE]   = enable_q;
      ctrl_rd[CTRL_IRQ_EN]   = irq_en_q;
      status_rd              = '0;
      status_rd[STAT_EMPTY]  = fifo_empty;
      status_rd[STAT_FULL]   = fifo_full;
      status_rd[STAT_OVF]    = ovf_q;
      status_rd[STAT_UDF]    = udf_q;
   end

   // Register file next-state, FIFO strobes and read mux for the accepted transfer.
   always_comb begin
      enable_d = enable_q;
      irq_en_d = irq_en_q;
      thresh_d = thresh_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      rdata_d  = '0;
      push     = 1'b0;
      pop      = 1'b0;
      flush    = 1'b0;
      if (hit && hba_rnw) begin
         case (reg_addr)
            REG_ADDR_WIDTH'(REG_CTRL):   rdata_d = ctrl_rd;
            REG_ADDR_WIDTH'(REG_STATUS): rdata_d = status_rd;
            REG_ADDR_WIDTH'(REG_COUNT):  rdata_d = count_ext;
            REG_ADDR_WIDTH'(REG_THRESH): rdata_d = thresh_q;
            REG_ADDR_WIDTH'(REG_DATA): begin
               if (enable_q) begin
                  if (fifo_empty) begin
                     udf_d = 1'b1;
                  end else begin
                     pop     = 1'b1;
                     rdata_d = fifo_dout;
                  end
               end
            end
            default: rdata_d = '0;
         endcase
      end else if (hit) begin
         case (reg_addr)
            REG_ADDR_WIDTH'(REG_CTRL): begin
               enable_d = hba_dbus[CTRL_ENABLE];
               irq_en_d = hba_dbus[CTRL_IRQ_EN];
               flush    = hba_dbus[CTRL_FLUSH];
            end
            REG_ADDR_WIDTH'(REG_STATUS): begin
               if (hba_dbus[STAT_OVF]) ovf_d = 1'b0;
               if (hba_dbus[STAT_UDF]) udf_d = 1'b0;
            end
            REG_ADDR_WIDTH'(REG_THRESH): thresh_d = hba_dbus;
            REG_ADDR_WIDTH'(REG_DATA): begin
               if (enable_q) begin
                  if (fifo_full) ovf_d = 1'b1;
                  else           push  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Level interrupt from current registered state, so it trails COUNT by one cycle.
   assign irq_d = irq_en_q & enable_q & (thresh_q != '0) & (count_ext >= thresh_q);

   // Bus-side and register state with synchronous active-low reset.
   always_ff @(posedge hba_clk) begin
      if (!hba_reset) begin
         ack_q    <= 1'b0;
         rdata_q  <= '0;
         enable_q <= 1'b0;
         irq_en_q <= 1'b0;
         thresh_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         ack_q    <= hit;
         rdata_q  <= rdata_d;
         enable_q <= enable_d;
         irq_en_q <= irq_en_d;
         thresh_q <= thresh_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         irq_q    <= irq_d;
      end
   end

   assign hba_xferack_slave = ack_q;
   assign hba_dbus_slave    = rdata_q;
   assign slave_interrupt   = irq_q;

endmodule

// File: tb/tb_hba_mailbox.sv
// Directed bench for hba_mailbox with hand-computed expected values.
module tb_hba_mailbox;

   logic        hba_clk = 1'b0;
   logic        hba_reset;
   logic [11:0] hba_abus;
   logic        hba_select;
   logic        hba_rnw;
   logic [7:0]  hba_dbus;
   logic        hba_xferack_slave;
   logic [7:0]  hba_dbus_slave;
   logic        slave_interrupt;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] A_CTRL   = 8'h00;
   localparam logic [7:0] A_STATUS = 8'h01;
   localparam logic [7:0] A_COUNT  = 8'h02;
   localparam logic [7:0] A_DATA   = 8'h03;
   localparam logic [7:0] A_THRESH = 8'h04;
   localparam logic [7:0] A_UNUSED = 8'h20;

   always #5 hba_clk = ~hba_clk;

   hba_mailbox dut (
      .hba_clk           (hba_clk),
      .hba_reset         (hba_reset),
      .hba_abus          (hba_abus),
      .hba_select        (hba_select),
      .hba_rnw           (hba_rnw),
      .hba_dbus          (hba_dbus),
      .hba_xferack_slave (hba_xferack_slave),
      .hba_dbus_slave    (hba_dbus_slave),
      .slave_interrupt   (slave_interrupt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transfer on own slot; select is held through the ack cycle to prove a single ack.
   task automatic xfer(input logic rnw, input logic [7:0] reg_a, input logic [7:0] wdata,
                       output logic [7:0] rdata, output logic irq_at_ack);
      hba_abus   = {4'h0, reg_a};
      hba_rnw    = rnw;
      hba_dbus   = wdata;
      hba_select = 1'b1;
      @(posedge hba_clk); #1;
      check("ack", hba_xferack_slave, 1'b1);
      rdata      = hba_dbus_slave;
      irq_at_ack = slave_interrupt;
      if (!rnw) check("wr_rdata_zero", hba_dbus_slave, 8'h00);
      @(posedge hba_clk); #1;
      check("single_ack", hba_xferack_slave, 1'b0);
      check("rdata_idle", hba_dbus_slave, 8'h00);
      hba_select = 1'b0;
   endtask

   task automatic wr(input logic [7:0] reg_a, input logic [7:0] wdata);
      logic [7:0] d;
      logic       i;
      xfer(1'b0, reg_a, wdata, d, i);
   endtask

   task automatic rd(input string tag, input logic [7:0] reg_a, input logic [7:0] exp);
      logic [7:0] d;
      logic       i;
      xfer(1'b1, reg_a, 8'h00, d, i);
      check(tag, d, exp);
   endtask

   // Drive a transfer that must not be acknowledged for a few cycles.
   task automatic no_ack(input string tag, input logic [11:0] addr, input logic rnw);
      hba_abus   = addr;
      hba_rnw    = rnw;
      hba_dbus   = 8'hEE;
      hba_select = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge hba_clk); #1;
         check(tag, hba_xferack_slave, 1'b0);
      end
      hba_select = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       irq_ack;

      // Reset with select held on own slot
      hba_reset  = 1'b0;
      hba_abus   = {4'h0, A_STATUS};
      hba_rnw    = 1'b1;
      hba_dbus   = 8'h00;
      hba_select = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge hba_clk); #1;
         check("rst_ack", hba_xferack_slave, 1'b0);
         check("rst_dbus", hba_dbus_slave, 8'h00);
         check("rst_irq", slave_interrupt, 1'b0);
      end
      hba_select = 1'b0;
      hba_reset  = 1'b1;
      @(posedge hba_clk); #1;
      check("post_rst_ack", hba_xferack_slave, 1'b0);

      rd("rst_status", A_STATUS, 8'h01);
      rd("rst_ctrl",   A_CTRL,   8'h00);
      rd("rst_count",  A_COUNT,  8'h00);
      rd("rst_thresh", A_THRESH, 8'h00);

      // Basic push/pop ordering
      wr(A_CTRL, 8'h01);
      rd("ctrl_en", A_CTRL, 8'h01);
      wr(A_DATA, 8'hA5);
      wr(A_DATA, 8'h5A);
      rd("count2", A_COUNT, 8'h02);
      rd("status_nonempty", A_STATUS, 8'h00);
      rd("pop_a5", A_DATA, 8'hA5);
      rd("pop_5a", A_DATA, 8'h5A);
      rd("status_empty", A_STATUS, 8'h01);

      // Fill past depth
      for (int i = 0; i < 17; i++) wr(A_DATA, 8'h10 + 8'(i));
      rd("count_full", A_COUNT, 8'h10);
      rd("status_full_ovf", A_STATUS, 8'h06);
      wr(A_STATUS, 8'h04);
      rd("status_ovf_clr", A_STATUS, 8'h02);
      rd("pop_head", A_DATA, 8'h10);
      rd("count15", A_COUNT, 8'h0F);

      // Flush keeps enable, self-clears
      wr(A_CTRL, 8'h05);
      rd("flush_count", A_COUNT, 8'h00);
      rd("flush_ctrl", A_CTRL, 8'h01);
      rd("flush_status", A_STATUS, 8'h01);

      // Underflow and disabled behaviour
      rd("udf_data", A_DATA, 8'h00);
      rd("udf_status", A_STATUS, 8'h09);
      wr(A_STATUS, 8'h08);
      rd("udf_clr", A_STATUS, 8'h01);
      wr(A_CTRL, 8'h00);
      wr(A_DATA, 8'h77);
      rd("dis_count", A_COUNT, 8'h00);
      rd("dis_data", A_DATA, 8'h00);
      rd("dis_status", A_STATUS, 8'h01);

      // Threshold interrupt
      wr(A_THRESH, 8'h03);
      rd("thresh", A_THRESH, 8'h03);
      wr(A_CTRL, 8'h03);
      check("irq_idle", slave_interrupt, 1'b0);
      wr(A_DATA, 8'h11);
      wr(A_DATA, 8'h22);
      check("irq_below", slave_interrupt, 1'b0);
      xfer(1'b0, A_DATA, 8'h33, d, irq_ack);
      check("irq_at_third_ack", irq_ack, 1'b0);
      check("irq_rise", slave_interrupt, 1'b1);
      xfer(1'b0, A_CTRL, 8'h07, d, irq_ack);
      check("irq_at_flush_ack", irq_ack, 1'b1);
      check("irq_fall", slave_interrupt, 1'b0);
      rd("irq_count", A_COUNT, 8'h00);
      rd("irq_ctrl", A_CTRL, 8'h03);

      // Foreign slot and unused register
      no_ack("other_slot_wr", {4'h1, A_DATA}, 1'b0);
      no_ack("other_slot_rd", {4'h1, A_STATUS}, 1'b1);
      rd("other_count", A_COUNT, 8'h00);
      wr(A_UNUSED, 8'hFF);
      rd("unused_rd", A_UNUSED, 8'h00);
      rd("unused_ctrl", A_CTRL, 8'h03);
      rd("unused_thresh", A_THRESH, 8'h03);
      rd("unused_status", A_STATUS, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hba_mailbox.md
# hba_mailbox

HBA bus slave (responder) peripheral providing a byte mailbox: any HBA master pushes bytes by writing a data register and pops them by reading the same register, with status, occupancy and threshold-interrupt registers. Sits in one peripheral slot on the HBA bus, on the responder side of the transfers an HBA master issues. Lets a hardware state-machine master and a host-bridge master exchange data without a processor.

## Interface
- DBUS_WIDTH, 8, data bus width.
- PERIPH_ADDR_WIDTH, 4, slot-address width.
- REG_ADDR_WIDTH, 8, register-address width.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, full bus address width.
- PERIPH_ADDR, 0, slot this instance answers.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries; legal range 1..7.

- hba_clk  in  1  bus clock; single clock domain.
- hba_reset  in  1  synchronous, active-low reset.
- hba_abus  in  ADDR_WIDTH  transfer address.
- hba_select  in  1  transfer in progress.
- hba_rnw  in  1  1=read, 0=write.
- hba_dbus  in  DBUS_WIDTH  write data from master.
- hba_xferack_slave  out  1  one-cycle transfer acknowledge; 0 when not acking.
- hba_dbus_slave  out  DBUS_WIDTH  read data; 0 except during a read ack.
- slave_interrupt  out  1  level interrupt.

## Operation
- Hit = hba_select & (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR) & !hba_xferack_slave.
- Registers (reg address = hba_abus[REG_ADDR_WIDTH-1:0]):
  - 0 CTRL rw: bit0 enable, bit1 irq_en, bit2 flush (write-1, self-clearing, reads 0).
  - 1 STATUS ro: bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky). Writing 1 to bit2/bit3 clears that bit.
  - 2 COUNT ro: occupancy, zero-extended.
  - 3 DATA: write pushes hba_dbus; read pops head byte.
  - 4 THRESH rw: interrupt threshold.
  - Any other address: read returns 0, write ignored, still acked.
- Push when full: byte dropped, overflow<=1. Pop when empty: returns 0, underflow<=1.
- enable=0: DATA writes and reads are acked; no push/pop; reads return 0; sticky flags unchanged.
- flush: occupancy->0, pointers->0; a flush write and a DATA push cannot coincide (one transfer per ack); flush does not clear sticky flags.
- slave_interrupt = irq_en & enable & (THRESH!=0) & (COUNT>=THRESH), registered.
- Pointers wrap modulo 2^DEPTH_LOG2; COUNT is DEPTH_LOG2+1 bits.

## Timing
- Reset (hba_reset=0 at clock edge): hba_xferack_slave=0, hba_dbus_slave=0, slave_interrupt=0, CTRL=0, THRESH=0, FIFO empty, sticky flags 0.
- Hit sampled at edge N -> hba_xferack_slave=1 for exactly cycle N+1; read data valid on hba_dbus_slave in that same cycle, registered.
- Register write / push / pop / flag update all take effect at edge N (visible to transfers starting N+1 or later).
- No hit is accepted in the ack cycle, so a master holding select one cycle past ack never gets a double ack; back-to-back transfers sustain one per 2 cycles.
- STATUS/COUNT read reflect state before that transfer's own effect.
- slave_interrupt updates one cycle after COUNT changes.
- Reset asserted mid-transfer: ack suppressed at that edge; no pending ack after release.

## Structure
- Package hba_mailbox_pkg: register address constants (CTRL, STATUS, COUNT, DATA, THRESH) and CTRL/STATUS bit positions.
- Sub-module hba_mailbox_fifo: synchronous FIFO (push, pop, flush, dout, count, empty, full), DEPTH_LOG2 parameter, same clock/reset.
- Top: address decode, ack generation, register file, read mux, interrupt.

## Test plan
- Reset with select held high on own slot -> no ack while reset low; all outputs 0; STATUS read after reset returns 8'h01.
- CTRL=8'h01; write DATA 8'hA5, 8'h5A; read COUNT -> 2; read DATA twice -> 8'hA5 then 8'h5A; STATUS -> 8'h01; each transfer acked exactly one cycle after select.
- DEPTH_LOG2=4: push 17 bytes -> COUNT=16, STATUS=8'h06; write STATUS 8'h04 -> STATUS=8'h02.
- Enabled, empty: read DATA -> 8'h00, STATUS bit3=1; with enable=0, writes to DATA leave COUNT=0.
- THRESH=3, CTRL=8'h03: push 3 -> slave_interrupt rises one cycle after third push ack; write CTRL=8'h07 -> COUNT=0, interrupt falls, CTRL reads 8'h03.
- Transfer with different slot address or unused reg 8'h20 -> no ack for other slot; reg 8'h20 acked, reads 0, no state change.
